// File: rtl/piso_frame_tx.sv
// UART transmit framer: latches a byte plus parity mode, then shifts out
// start, data LSB-first, parity slot and stop bit(s), one bit per BaudOut edge.
module piso_frame_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  BaudOut,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] DataIn,
   input  logic [1:0]            ParityType,
   input  logic                  Send,
   output logic                  DataTx,
   output logic                  Busy,
   output logic                  Done
);

   // state   | meaning
   // IDLE    | line high, waiting for Send (also the cycle carrying Done)
   // START   | start bit (0) on the line
   // DATA    | payload bits, LSB first
   // PARITY  | parity slot (1 when parity is disabled)
   // STOP    | STOP_BITS cycles of 1
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  parity_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  parity_d;

   always_comb begin
      parity_d = 1'b1;
      case (ParityType)
         2'b01:   parity_d = ~^DataIn;
         2'b10:   parity_d = ^DataIn;
         default: parity_d = 1'b1;
      endcase
   end

   always_ff @(posedge BaudOut or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         parity_q <= 1'b1;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (Send) begin
                  shift_q  <= DataIn;
                  parity_q <= parity_d;
                  cnt_q    <= '0;
                  tx_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               tx_q    <= shift_q[0];
               shift_q <= shift_q >> 1;
               cnt_q   <= '0;
               state_q <= S_DATA;
            end
            S_DATA: begin
               if (cnt_q == LAST_DATA) begin
                  tx_q    <= parity_q;
                  state_q <= S_PARITY;
               end else begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  cnt_q   <= cnt_q + CNT_ONE;
               end
            end
            S_PARITY: begin
               tx_q    <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_STOP;
            end
            S_STOP: begin
               tx_q <= 1'b1;
               if (cnt_q == LAST_STOP) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  shift_q <= '0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign DataTx = tx_q;
   assign Busy   = busy_q;
   assign Done   = done_q;

endmodule
